sccb_arbiter: RTL and testbench
===============================

# sccb_arbiter

Shares the single SCCB master between two register-write requesters: port 0 for the power-on init sequencer and port 1 for the runtime tuner (exposure/gain/mirror writes). The block sits between those requesters and the SCCB master's i_fStart/i_Addr/i_Data/o_fReady handshake. It serialises one 8-bit-address/8-bit-data write at a time, arbitrates round-robin, and returns a per-port completion pulse.

## Interface
- WAIT_MAX, default 16, cycles allowed between the fStart pulse and o_fReady falling (busy-acknowledge guard), range 1..255
- TIMEOUT_CYCLES, default 2000000, cycles allowed in WAIT_READY; used only with SCCB_ARB_TIMEOUT_EN
- i_Clk  in  1  system clock
- i_Rst  in  1  asynchronous, active-high reset
- i_Req0 / i_Req1  in  1  write request; held high with address/data stable until the matching ack
- i_Addr0 / i_Addr1  in  8  camera register address
- i_Data0 / i_Data1  in  8  register value
- o_Ack0 / o_Ack1  out  1  one-cycle completion pulse
- o_Grant  out  2  one-hot owner of the current transaction; 00 when idle
- o_Busy  out  1  high in every state except IDLE
- o_SCCB_fStart  out  1  one-cycle start pulse to the SCCB master
- o_SCCB_Addr / o_SCCB_Data  out  8  latched address/data to the master
- i_SCCB_fReady  in  1  master idle flag
- o_TxnCnt  out  16  completed-write counter, wraps at 0xFFFF→0
- o_Err  out  1  sticky error flag; cleared only by reset

## Operation
- FSM states: IDLE, GRANT, ISSUE, WAIT_BUSY, WAIT_READY, ACK.
- IDLE: if any i_ReqN is high and i_SCCB_fReady=1, go to GRANT. Otherwise stay.
- Arbitration in IDLE, round-robin:
  - Pointer `last` holds the last granted port; reset value is 1, so port 0 wins first.
  - If both ports request, grant the port other than `last`.
  - If one port requests, grant it.
- GRANT: latch the winner's address/data into o_SCCB_Addr/o_SCCB_Data, set o_Grant, update `last`, then go to ISSUE.
- ISSUE: o_SCCB_fStart=1 for exactly this cycle, then go to WAIT_BUSY.
- WAIT_BUSY: wait for i_SCCB_fReady=0, then go to WAIT_READY.
  - If it stays high for WAIT_MAX cycles, set o_Err and go to ACK; the write is treated as lost.
- WAIT_READY: wait for i_SCCB_fReady=1, then go to ACK.
- ACK:
  - Pulse o_AckN for the granted port.
  - o_TxnCnt+1, but only when the write was not lost.
  - Clear o_Grant and return to IDLE.
- The requester must drop or change i_ReqN on the cycle after its ack. A request still high in IDLE is a new write.
- Request inputs are ignored outside IDLE. A request dropped before its grant is not serviced.
- o_SCCB_Addr/o_SCCB_Data hold their values from GRANT until the next GRANT.

## Timing
- Reset values: o_Ack0/1=0, o_Grant=00, o_Busy=0, o_SCCB_fStart=0, o_SCCB_Addr=0x00, o_SCCB_Data=0x00, o_TxnCnt=0, o_Err=0, state=IDLE, `last`=1.
- Request to start: request seen in IDLE at edge n → GRANT at n+1 → fStart high during cycle n+2.
- Transaction end: ack asserts one cycle after fReady is seen high in WAIT_READY.
- Back-to-back: after ACK, IDLE takes at least one cycle. Minimum 3 cycles from an ack to the next fStart.
- All outputs are registered. No combinational path from i_ReqN to o_SCCB_*.
- Reset asserted mid-transaction: all outputs immediately take their reset values (asynchronous). No ack is issued for the aborted write. The SCCB master shares i_Rst and is reset with it.

## Configuration
- SCCB_ARB_TIMEOUT_EN defined:
  - A 21-bit watchdog counts cycles in WAIT_READY.
  - When it reaches TIMEOUT_CYCLES: set o_Err, pulse the ack, do not increment o_TxnCnt, return to IDLE.
  - The watchdog clears on every state entry.
- Without the macro: WAIT_READY waits indefinitely, and no watchdog logic is synthesised.

## Test plan
- Port 0 writes addr 0x12/data 0x80; master model holds fReady low for 50 cycles → fStart at cycle 2, o_SCCB_Addr=0x12, o_SCCB_Data=0x80, o_Ack0 pulse 52 cycles later, o_TxnCnt=1.
- Both ports request continuously with distinct data → grants alternate 0,1,0,1; each ack matches its latched data; no fStart is issued while fReady=0.
- Request raised while fReady=0 in IDLE → no grant until fReady=1; the grant then follows on the next edge.
- Master never drops fReady after fStart, WAIT_MAX=16 → o_Err=1 after 16 cycles, ack pulses, o_TxnCnt unchanged.
- Reset asserted during WAIT_READY → all outputs at reset values the same cycle, no ack; after release a port 1 request is granted normally.
- With SCCB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=100, fReady stuck low → o_Err at cycle 100 of WAIT_READY, ack pulse, return to IDLE. Without the macro, same stimulus → o_Busy stays high.

Source files
------------

// File: rtl/sccb_arbiter_if.sv
// Requester-side and SCCB-master-side signals of sccb_arbiter.
// slave modport is the arbiter's view; master modport is the surrounding system's view.
interface sccb_arbiter_if;
  logic       i_Req0;
  logic       i_Req1;
  logic [7:0] i_Addr0;
  logic [7:0] i_Addr1;
  logic [7:0] i_Data0;
  logic [7:0] i_Data1;
  logic       o_Ack0;
  logic       o_Ack1;
  logic [1:0] o_Grant;
  logic       o_Busy;
  logic       o_SCCB_fStart;
  logic [7:0] o_SCCB_Addr;
  logic [7:0] o_SCCB_Data;
  logic       i_SCCB_fReady;
  logic [15:0] o_TxnCnt;
  logic       o_Err;

  modport slave (
    input  i_Req0, i_Req1, i_Addr0, i_Addr1, i_Data0, i_Data1, i_SCCB_fReady,
    output o_Ack0, o_Ack1, o_Grant, o_Busy, o_SCCB_fStart, o_SCCB_Addr, o_SCCB_Data,
           o_TxnCnt, o_Err
  );

  modport master (
    output i_Req0, i_Req1, i_Addr0, i_Addr1, i_Data0, i_Data1, i_SCCB_fReady,
    input  o_Ack0, o_Ack1, o_Grant, o_Busy, o_SCCB_fStart, o_SCCB_Addr, o_SCCB_Data,
           o_TxnCnt, o_Err
  );
endinterface

// File: rtl/sccb_arbiter.sv
// Round-robin arbiter sharing one SCCB master between the init sequencer (port 0) and tuner (port 1).
// Define SCCB_ARB_TIMEOUT_EN to add a WAIT_READY watchdog of TIMEOUT_CYCLES cycles.
//
// state        | meaning
// S_IDLE       | no transaction; arbitrate when the master is ready
// S_GRANT      | winner's address/data latched, grant visible
// S_ISSUE      | one-cycle start pulse to the SCCB master
// S_WAIT_BUSY  | waiting for the master to drop fReady (WAIT_MAX guard)
// S_WAIT_READY | master busy; waiting for fReady to return
// S_ACK        | completion pulse to the granted port
module sccb_arbiter #(
  parameter int unsigned WAIT_MAX       = 16,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic          i_Clk,
  input  logic          i_Rst,
  sccb_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_READY,
    S_ACK
  } state_t;

  localparam logic [7:0] LP_BUSY_LOAD = 8'(WAIT_MAX - 1);

  state_t      r_state;
  state_t      w_next;
  logic        w_any;
  logic        w_pick;
  logic        w_lost;
  logic        w_wdog_tc;
  logic        r_last;
  logic [1:0]  r_grant;
  logic [7:0]  r_addr;
  logic [7:0]  r_data;
  logic [7:0]  r_busy_cnt;
  logic [15:0] r_txn_cnt;
  logic        r_err;
  logic        r_fstart;
  logic        r_busy;
  logic        r_ack0;
  logic        r_ack1;

`ifdef SCCB_ARB_TIMEOUT_EN
  localparam logic [20:0] LP_WDOG_LOAD = 21'(TIMEOUT_CYCLES - 1);
  logic [20:0] r_wdog;

  assign w_wdog_tc = (r_wdog == 21'd0);

  // Reloads on every state change, so each WAIT_READY visit gets a full budget.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_wdog <= LP_WDOG_LOAD;
    end else if (r_state == S_WAIT_READY && w_next == S_WAIT_READY) begin
      r_wdog <= r_wdog - 21'd1;
    end else begin
      r_wdog <= LP_WDOG_LOAD;
    end
  end
`else
  assign w_wdog_tc = 1'b0;
  // Keeps TIMEOUT_CYCLES referenced when the watchdog is compiled out.
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

  always_comb begin
    w_any  = bus.i_Req0 | bus.i_Req1;
    w_pick = (bus.i_Req0 & bus.i_Req1) ? ~r_last : bus.i_Req1;
    w_next = r_state;
    w_lost = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any && bus.i_SCCB_fReady) w_next = S_GRANT;
      end
      S_GRANT: w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (!bus.i_SCCB_fReady) begin
          w_next = S_WAIT_READY;
        end else if (r_busy_cnt == 8'd0) begin
          w_next = S_ACK;
          w_lost = 1'b1;
        end
      end
      S_WAIT_READY: begin
        if (bus.i_SCCB_fReady) begin
          w_next = S_ACK;
        end else if (w_wdog_tc) begin
          w_next = S_ACK;
          w_lost = 1'b1;
        end
      end
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Outputs are registered from the next-state decode so they line up with the state.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_last     <= 1'b1;
      r_grant    <= 2'b00;
      r_addr     <= 8'h00;
      r_data     <= 8'h00;
      r_busy_cnt <= 8'd0;
      r_txn_cnt  <= 16'd0;
      r_err      <= 1'b0;
      r_fstart   <= 1'b0;
      r_busy     <= 1'b0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
    end else begin
      r_fstart <= (w_next == S_ISSUE);
      r_busy   <= (w_next != S_IDLE);
      r_ack0   <= (w_next == S_ACK) & r_grant[0];
      r_ack1   <= (w_next == S_ACK) & r_grant[1];

      if (r_state == S_IDLE && w_next == S_GRANT) begin
        r_grant <= w_pick ? 2'b10 : 2'b01;
        r_addr  <= w_pick ? bus.i_Addr1 : bus.i_Addr0;
        r_data  <= w_pick ? bus.i_Data1 : bus.i_Data0;
        r_last  <= w_pick;
      end else if (r_state == S_ACK) begin
        r_grant <= 2'b00;
      end

      if (r_state == S_ISSUE) begin
        r_busy_cnt <= LP_BUSY_LOAD;
      end else if (r_state == S_WAIT_BUSY && r_busy_cnt != 8'd0) begin
        r_busy_cnt <= r_busy_cnt - 8'd1;
      end

      if (r_state == S_WAIT_READY && w_next == S_ACK && !w_lost) begin
        r_txn_cnt <= r_txn_cnt + 16'd1;
      end

      if (w_lost) r_err <= 1'b1;
    end
  end

  assign bus.o_Ack0        = r_ack0;
  assign bus.o_Ack1        = r_ack1;
  assign bus.o_Grant       = r_grant;
  assign bus.o_Busy        = r_busy;
  assign bus.o_SCCB_fStart = r_fstart;
  assign bus.o_SCCB_Addr   = r_addr;
  assign bus.o_SCCB_Data   = r_data;
  assign bus.o_TxnCnt      = r_txn_cnt;
  assign bus.o_Err         = r_err;

endmodule

// File: tb/tb_sccb_arbiter.sv
// Self-checking bench for sccb_arbiter: randomized requesters and SCCB master model,
// checked against a transaction-level round-robin reference.
module tb_sccb_arbiter;
  localparam int WMAX = 16;
  localparam int TMO  = 100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sccb_arbiter_if bus ();

  sccb_arbiter #(.WAIT_MAX(WMAX), .TIMEOUT_CYCLES(TMO)) dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic       rq [2];
  logic [7:0] ra [2];
  logic [7:0] rd [2];
  logic [2:0] h0, h1;
  bit         rnd_on;
  int         m_mode;
  int         m_rem;
  logic       m_ready;
  int         next_low;
  int         last_m, cnt_m;
  bit         err_m;
  int         exp_port, fs_cyc, ack_cyc, exp_lat;
  bit         exp_lost;
  int         n_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive();
    bus.i_Req0        = rq[0];
    bus.i_Req1        = rq[1];
    bus.i_Addr0       = ra[0];
    bus.i_Addr1       = rd[0] ^ rd[0] ^ ra[1];
    bus.i_Data0       = rd[0];
    bus.i_Data1       = rd[1];
    bus.i_SCCB_fReady = m_ready;
  endtask

  task automatic model_reset();
    last_m   = 1;
    cnt_m    = 0;
    err_m    = 1'b0;
    exp_port = -1;
    ack_cyc  = -1;
    m_ready  = 1'b1;
    m_rem    = 0;
    m_mode   = 0;
    rq[0]    = 1'b0;
    rq[1]    = 1'b0;
    h0       = 3'b100;
    h1       = 3'b100;
  endtask

  task automatic chk_reset_vals(input string p);
    chk({p, "_ack"},   {30'd0, bus.o_Ack1, bus.o_Ack0}, 0);
    chk({p, "_grant"}, {30'd0, bus.o_Grant}, 0);
    chk({p, "_busy"},  {31'd0, bus.o_Busy}, 0);
    chk({p, "_fs"},    {31'd0, bus.o_SCCB_fStart}, 0);
    chk({p, "_addr"},  {24'd0, bus.o_SCCB_Addr}, 0);
    chk({p, "_data"},  {24'd0, bus.o_SCCB_Data}, 0);
    chk({p, "_cnt"},   {16'd0, bus.o_TxnCnt}, 0);
    chk({p, "_err"},   {31'd0, bus.o_Err}, 0);
  endtask

  // One clock: observe at the falling edge, update the models, then drive the next inputs.
  task automatic tick();
    logic [1:0] ack;
    int w;
    int low;
    @(negedge clk);
    cyc++;
    ack = {bus.o_Ack1, bus.o_Ack0};
    if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) m_ready = 1'b1;
    end
    if (bus.o_SCCB_fStart) begin
      chk("fs_ready_at_grant", {31'd0, h1[2]}, 1);
      chk("fs_had_request", {31'd0, |h1[1:0]}, 1);
      w = (h1[1:0] == 2'b11) ? ((last_m == 0) ? 1 : 0) : (h1[1] ? 1 : 0);
      last_m = w;
      chk("fs_prev_done", exp_port, -1);
      chk("fs_grant", {30'd0, bus.o_Grant}, 1 << w);
      chk("fs_addr", {24'd0, bus.o_SCCB_Addr}, {24'd0, ra[w]});
      chk("fs_data", {24'd0, bus.o_SCCB_Data}, {24'd0, rd[w]});
      chk("fs_busy", {31'd0, bus.o_Busy}, 1);
      if (ack_cyc >= 0) chk("ack_to_fs_gap", (cyc - ack_cyc) >= 3, 1);
      exp_port = w;
      fs_cyc   = cyc;
      if (rnd_on) m_mode = ($urandom_range(0, 7) == 0) ? 1 : 0;
      case (m_mode)
        0: begin
          low      = (next_low > 0) ? next_low : int'($urandom_range(1, 20));
          next_low = 0;
          m_rem    = low + 1;
          m_ready  = 1'b0;
          exp_lat  = low + 2;
          exp_lost = 1'b0;
        end
        1: begin
          exp_lat  = 1 + WMAX;
          exp_lost = 1'b1;
        end
        default: begin
          m_ready = 1'b0;
          m_rem   = 0;
`ifdef SCCB_ARB_TIMEOUT_EN
          exp_lat  = 2 + TMO;
          exp_lost = 1'b1;
`else
          exp_lat  = 1000000;
          exp_lost = 1'b0;
`endif
        end
      endcase
    end
    if (ack != 2'b00) begin
      chk("ack_port", {30'd0, ack}, (exp_port < 0) ? 0 : (1 << exp_port));
      if (exp_port >= 0) begin
        chk("ack_latency", cyc - fs_cyc, exp_lat);
        chk("ack_grant", {30'd0, bus.o_Grant}, 1 << exp_port);
        if (exp_lost) err_m = 1'b1;
        else          cnt_m = (cnt_m + 1) & 16'hFFFF;
        chk("txn_cnt", {16'd0, bus.o_TxnCnt}, cnt_m);
        chk("err_flag", {31'd0, bus.o_Err}, {31'd0, err_m});
        if (rnd_on && $urandom_range(0, 1) == 1) begin
          ra[exp_port] = 8'($urandom);
          rd[exp_port] = 8'($urandom);
        end else begin
          rq[exp_port] = 1'b0;
        end
        exp_port = -1;
        ack_cyc  = cyc;
        n_done++;
      end
    end
    if (rnd_on) begin
      for (int i = 0; i < 2; i++) begin
        if (!rq[i] && $urandom_range(0, 3) == 0) begin
          rq[i] = 1'b1;
          ra[i] = 8'($urandom);
          rd[i] = 8'($urandom);
        end
      end
    end
    drive();
    h1 = h0;
    h0 = {m_ready, rq[1], rq[0]};
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int k = 0;
    while (n_done < target && k < budget) begin
      tick();
      k++;
    end
    chk(tag, n_done >= target, 1);
  endtask

  initial begin
    #600000;
    $display("FAIL global_timeout: got=running exp=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int c0;
    int k;
    rst      = 1'b1;
    rnd_on   = 1'b0;
    next_low = 0;
    n_done   = 0;
    ra[0] = 8'h00; ra[1] = 8'h00; rd[0] = 8'h00; rd[1] = 8'h00;
    model_reset();
    drive();
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst = 1'b0;
    tick();
    tick();

    // Port 0 single write, master busy for 50 cycles.
    rq[0] = 1'b1; ra[0] = 8'h12; rd[0] = 8'h80; next_low = 50;
    tick();
    c0 = cyc;
    wait_done(1, 200, "t1_done");
    chk("t1_fs_delay", fs_cyc - c0, 2);

    // Randomized traffic from both ports, occasional lost writes.
    rnd_on = 1'b1;
    wait_done(n_done + 60, 8000, "t2_done");
    rnd_on = 1'b0;
    m_mode = 0;
    k = 0;
    while ((rq[0] || rq[1] || exp_port >= 0) && k < 400) begin
      tick();
      k++;
    end
    chk("t2_drain", (rq[0] || rq[1] || exp_port >= 0), 0);

    // Master not ready in IDLE: request (and a dropped one) must wait.
    m_ready = 1'b0;
    tick();
    rq[1] = 1'b1; ra[1] = 8'h77; rd[1] = 8'h66;
    tick();
    tick();
    rq[1] = 1'b0;
    tick();
    rq[0] = 1'b1; ra[0] = 8'h5A; rd[0] = 8'hA5;
    repeat (8) tick();
    chk("t3_hold_grant", {30'd0, bus.o_Grant}, 0);
    chk("t3_hold_busy", {31'd0, bus.o_Busy}, 0);
    m_ready = 1'b1;
    tick();
    c0 = cyc;
    tick();
    chk("t3_grant_next", {30'd0, bus.o_Grant}, 1);
    wait_done(n_done + 1, 200, "t3_done");
    chk("t3_fs_delay", fs_cyc - c0, 2);

    // Master never drops fReady: busy-acknowledge guard.
    m_mode = 1;
    rq[1] = 1'b1; ra[1] = 8'h3A; rd[1] = 8'h01;
    wait_done(n_done + 1, 200, "t4_done");
    chk("t4_err", {31'd0, bus.o_Err}, 1);
    m_mode = 0;

    // fReady stuck low after the start pulse.
    m_mode = 2;
    rq[0] = 1'b1; ra[0] = 8'h0C; rd[0] = 8'h40;
    k = 0;
    while (exp_port < 0 && k < 50) begin
      tick();
      k++;
    end
    chk("t5_started", exp_port, 0);
`ifdef SCCB_ARB_TIMEOUT_EN
    wait_done(n_done + 1, 400, "t5_timeout_ack");
    m_ready = 1'b1;
    m_mode  = 0;
    tick();
    chk("t5_idle_after", {31'd0, bus.o_Busy}, 0);
`else
    c0 = n_done;
    repeat (300) tick();
    chk("t5_busy_stuck", {31'd0, bus.o_Busy}, 1);
    chk("t5_no_ack", n_done, c0);
    exp_lat = (cyc + 2) - fs_cyc;
    m_ready = 1'b1;
    m_mode  = 0;
    wait_done(c0 + 1, 10, "t5_release");
`endif

    // Reset in WAIT_READY, then a normal port 1 write.
    next_low = 40;
    rq[0] = 1'b1; ra[0] = 8'h21; rd[0] = 8'h9E;
    k = 0;
    while (exp_port < 0 && k < 50) begin
      tick();
      k++;
    end
    repeat (10) tick();
    chk("t6_in_flight", {31'd0, bus.o_Busy}, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_vals("t6_rst");
    model_reset();
    drive();
    @(negedge clk);
    chk_reset_vals("t6_hold");
    rst = 1'b0;
    tick();
    rq[1] = 1'b1; ra[1] = 8'h3C; rd[1] = 8'hC3;
    wait_done(n_done + 1, 200, "t6_after_reset");
    chk("t6_cnt", {16'd0, bus.o_TxnCnt}, cnt_m);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
